// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one byte-level UART transmitter among NUM_REQ requesters.
//   Round-robin arbitration; a grant is held for a whole packet (up to the
//   byte flagged req_last) unless MAX_BURST bytes have been sent or the
//   granted requester stalls for HOLD_TIMEOUT cycles mid-packet.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   req_valid  per-requester byte available
//   req_data   per-requester byte, requester i on [8i+7:8i]
//   req_last   per-requester end-of-packet flag for the offered byte
//   req_ready  one-hot consume pulse back to the granted requester
//   tx_data    byte to the transmitter, valid while tx_start=1 (else 0)
//   tx_start   one-cycle launch pulse to the transmitter
//   tx_busy    transmitter frame in progress
//   grant_id   current / last granted requester
//   active     a grant is held (state is not IDLE)
//
// Handshake: a requester raises req_valid with req_data/req_last and keeps
// all three stable until it sees req_ready. req_ready is a single-cycle
// pulse meaning the byte is consumed at the end of that cycle; it only
// occurs together with tx_start for the granted requester.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 16,
  parameter int HOLD_TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_start,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       active
);

  localparam int GW = $clog2(NUM_REQ);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_WAIT_HI = 3'd2;
  localparam logic [2:0] S_WAIT_LO = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;

  localparam logic [7:0]         MAX_BURST_C = 8'(MAX_BURST);
  localparam logic [7:0]         HOLD_C      = 8'(HOLD_TIMEOUT);
  localparam logic [GW:0]        NUM_C       = (GW+1)'(NUM_REQ);
  localparam logic [GW-1:0]      LAST_ID     = GW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0    = NUM_REQ'(1);

  logic [2:0]    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_q, rr_d;
  logic [7:0]    burst_q, burst_d;
  logic [7:0]    hold_q, hold_d;
  logic          last_q, last_d;

  // Round-robin search: rotate the valid vector so rr_q sits at bit 0, pick
  // the lowest set bit, then map the offset back to a requester index.
  logic [2*NUM_REQ-1:0] rot_valid;
  logic                 win_vld;
  logic [GW-1:0]        win_off;
  logic [GW:0]          win_sum;
  logic [GW-1:0]        win_id;

  assign rot_valid = {req_valid, req_valid} >> rr_q;

  always_comb begin
    win_vld = 1'b0;
    win_off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot_valid[i]) begin
        win_vld = 1'b1;
        win_off = GW'(i);
      end
    end
  end

  assign win_sum = {1'b0, rr_q} + {1'b0, win_off};
  assign win_id  = (win_sum >= NUM_C) ? GW'(win_sum - NUM_C) : GW'(win_sum);

  // Saturating hold counter increment, used for the timeout comparison.
  logic [7:0] hold_inc;
  assign hold_inc = (hold_q == 8'hFF) ? 8'hFF : hold_q + 8'd1;

  logic rel;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    burst_d = burst_q;
    hold_d  = hold_q;
    last_d  = last_q;
    rel     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          grant_d = win_id;
          state_d = S_START;
        end
      end
      S_START: begin
        if (burst_q != 8'hFF) burst_d = burst_q + 8'd1;
        last_d  = req_last[grant_q];
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (tx_busy) state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!tx_busy) begin
          if (last_q || (burst_q == MAX_BURST_C)) begin
            rel = 1'b1;
          end else if (req_valid[grant_q]) begin
            state_d = S_START;
          end else begin
            state_d = S_HOLD;
            hold_d  = 8'd0;
          end
        end
      end
      S_HOLD: begin
        if (req_valid[grant_q]) begin
          state_d = S_START;
        end else begin
          hold_d = hold_inc;
          if (hold_inc == HOLD_C) rel = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Release hands priority to the requester after the one just served.
    if (rel) begin
      state_d = S_IDLE;
      burst_d = 8'd0;
      rr_d    = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      burst_q <= 8'd0;
      hold_q  <= 8'd0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      burst_q <= burst_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  // Outputs decode straight from state so reset clears them immediately.
  assign tx_start  = (state_q == S_START);
  assign tx_data   = tx_start ? req_data[{grant_q, 3'b000} +: 8] : 8'h00;
  assign req_ready = tx_start ? (ONE_HOT0 << grant_q) : '0;
  assign grant_id  = grant_q;
  assign active    = (state_q != S_IDLE);

endmodule
